// File: rtl/fp21_add_sched_pkg.sv
// Shared FP21 definitions: field widths, adder latency, operand struct, clog2 helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`ifndef FP21_EXP_MSB
`define FP21_EXP_MSB 5
`endif
`ifndef FP21_FRAC_MSB
`define FP21_FRAC_MSB 13
`endif

package fp21_add_sched_pkg;

  localparam int FP21_EXP_W   = `FP21_EXP_MSB + 1;
  localparam int FP21_FRAC_W  = `FP21_FRAC_MSB + 1;
  localparam int FP21_ADD_LAT = 11;

  // One FP21 operand: sign, signed exponent, normalized fraction with explicit MSB.
  typedef struct packed {
    logic                   sign;
    logic [FP21_EXP_W-1:0]  expo;
    logic [FP21_FRAC_W-1:0] frac;
  } fp21_t;

  // Ceiling log2, never below 1 so it can size an index or counter directly.
  function automatic int clog2(input int value);
    int r;
    for (r = 1; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/FP21_add.sv
// Pipelined FP21 adder: magnitude-ordered align, add/subtract, renormalize (truncating).
// Latency: FP21_ADD_LAT clocks from operand inputs to sum outputs, one operation per clock.
// Backpressure: none; the data pipeline has no enable and no reset.
module FP21_add
  import fp21_add_sched_pkg::*;
(
  input  logic                   clk,
  input  logic                   a_sign,
  input  logic [FP21_EXP_W-1:0]  a_exp,
  input  logic [FP21_FRAC_W-1:0] a_frac,
  input  logic                   b_sign,
  input  logic [FP21_EXP_W-1:0]  b_exp,
  input  logic [FP21_FRAC_W-1:0] b_frac,
  output logic                   sum_sign,
  output logic [FP21_EXP_W-1:0]  sum_exp,
  output logic [FP21_FRAC_W-1:0] sum_frac
);

  localparam int EW  = FP21_EXP_W;
  localparam int FW  = FP21_FRAC_W;
  localparam int LZW = clog2(FW);

  logic           a_big;
  logic           big_sign, sml_sign;
  logic [EW-1:0]  big_exp, sml_exp;
  logic [FW-1:0]  big_frac, sml_frac, sml_aln;
  logic [EW:0]    exp_diff;
  logic [FW:0]    mag;
  logic [LZW-1:0] lz;
  logic           lead_found;
  fp21_t          sum_c;
  fp21_t          pipe [FP21_ADD_LAT];

  // Order operands by magnitude; a zero fraction never wins, so its exponent is irrelevant.
  always_comb begin
    if (b_frac == '0)                       a_big = 1'b1;
    else if (a_frac == '0)                  a_big = 1'b0;
    else if ($signed(a_exp) != $signed(b_exp)) a_big = $signed(a_exp) > $signed(b_exp);
    else                                    a_big = (a_frac >= b_frac);
    big_sign = a_big ? a_sign : b_sign;
    sml_sign = a_big ? b_sign : a_sign;
    big_exp  = a_big ? a_exp  : b_exp;
    sml_exp  = a_big ? b_exp  : a_exp;
    big_frac = a_big ? a_frac : b_frac;
    sml_frac = a_big ? b_frac : a_frac;
    exp_diff = {big_exp[EW-1], big_exp} - {sml_exp[EW-1], sml_exp};
    sml_aln  = (exp_diff >= (EW+1)'(FW)) ? '0 : (sml_frac >> exp_diff);
  end

  // Add or subtract aligned magnitudes and renormalize; an exact cancel yields +0.
  always_comb begin
    mag        = '0;
    lz         = '0;
    lead_found = 1'b0;
    sum_c.sign = big_sign;
    sum_c.expo = big_exp;
    sum_c.frac = big_frac;
    if (big_sign == sml_sign) begin
      mag = {1'b0, big_frac} + {1'b0, sml_aln};
      if (mag[FW]) begin
        sum_c.frac = mag[FW:1];
        sum_c.expo = big_exp + EW'(1);
      end else begin
        sum_c.frac = mag[FW-1:0];
      end
    end else begin
      mag = {1'b0, big_frac} - {1'b0, sml_aln};
      for (int k = FW - 1; k >= 0; k--) begin
        if (!lead_found && mag[k]) begin
          lead_found = 1'b1;
          lz         = LZW'(FW - 1 - k);
        end
      end
      if (lead_found) begin
        sum_c.frac = mag[FW-1:0] << lz;
        sum_c.expo = big_exp - EW'(lz);
      end else begin
        sum_c = '0;
      end
    end
  end

  // Plain delay line; validity is tracked by whoever drives this adder.
  always_ff @(posedge clk) begin
    pipe[0] <= sum_c;
    for (int s = 1; s < FP21_ADD_LAT; s++) pipe[s] <= pipe[s-1];
  end

  assign sum_sign = pipe[FP21_ADD_LAT-1].sign;
  assign sum_exp  = pipe[FP21_ADD_LAT-1].expo;
  assign sum_frac = pipe[FP21_ADD_LAT-1].frac;

endmodule

// File: rtl/fp21_rr_arbiter.sv
// Round-robin arbiter with optional fixed priority for requester 0.
// Latency: combinational; grant and next pointer are pure functions of eligible/ptr.
// Backpressure: an ineligible requester is skipped; no grant when none is eligible.
module fp21_rr_arbiter
  import fp21_add_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic            prio_en,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   ptr_nxt
);

  int   idx;
  int   nxt;
  logic found;

  // Requester 0 pre-empts under priority mode without moving the pointer; otherwise scan
  // upward from ptr with wrap. In priority mode requester 0 is ineligible whenever the scan
  // runs, and the pointer wraps to 1 so it only ever covers 1..NREQ-1.
  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = 0;
    nxt     = 0;
    if (prio_en && eligible[0]) begin
      grant[0] = 1'b1;
      found    = 1'b1;
    end
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        nxt        = idx + 1;
        if (nxt >= NREQ) nxt = prio_en ? 1 : 0;
        ptr_nxt    = IW'(nxt);
      end
    end
  end

endmodule

// File: rtl/fp21_add_sched.sv
// Shares one FP21_add pipeline among NREQ requesters; build option FP21_ADD_SCHED_PRIO_EN gives requester 0 fixed priority.
// Latency: issue sampled at edge T returns res_valid/res_id with the sum after edge T+LAT-1.
// Backpressure: one grant per cycle, gated by MAX_OUT per-requester credits; results cannot be stalled.
module fp21_add_sched
  import fp21_add_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LAT     = FP21_ADD_LAT,  // must match the instantiated FP21_add
  parameter int MAX_OUT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0]            req_sign_a,
  input  logic [NREQ-1:0]            req_sign_b,
  input  logic [NREQ*FP21_EXP_W-1:0] req_exp_a,
  input  logic [NREQ*FP21_EXP_W-1:0] req_exp_b,
  input  logic [NREQ*FP21_FRAC_W-1:0] req_frac_a,
  input  logic [NREQ*FP21_FRAC_W-1:0] req_frac_b,
  output logic                       res_valid,
  output logic [clog2(NREQ)-1:0]     res_id,
  output logic                       res_sign,
  output logic [FP21_EXP_W-1:0]      res_exp,
  output logic [FP21_FRAC_W-1:0]     res_frac,
  output logic                       busy
);

  localparam int EW = FP21_EXP_W;
  localparam int FW = FP21_FRAC_W;
  localparam int IW = clog2(NREQ);
  localparam int OW = clog2(MAX_OUT + 1);

`ifdef FP21_ADD_SCHED_PRIO_EN
  localparam logic          PRIO_EN = 1'b1;
  localparam logic [IW-1:0] PTR_RST = IW'(1);
`else
  localparam logic          PRIO_EN = 1'b0;
  localparam logic [IW-1:0] PTR_RST = '0;
`endif

  logic [IW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [NREQ-1:0] eligible, grant, retire;
  logic [OW-1:0]   outstanding [NREQ];
  logic            issue;
  logic [IW-1:0]   win_id;
  fp21_t           win_a, win_b, hold_a, hold_b, add_a, add_b;
  logic [LAT-1:0]  vld_sr;
  logic [IW-1:0]   id_sr [LAT];

  // Credit check; a credit retiring this cycle is reusable immediately so a requester at
  // its limit can issue in the same cycle its oldest result comes back.
  always_comb begin
    eligible = '0;
    retire   = '0;
    for (int i = 0; i < NREQ; i++) begin
      retire[i]   = res_valid && (res_id == IW'(i));
      eligible[i] = req_valid[i] && !rst &&
                    ((outstanding[i] < OW'(MAX_OUT)) || retire[i]);
    end
  end

  fp21_rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .eligible (eligible),
    .prio_en  (PRIO_EN),
    .ptr      (rr_ptr),
    .grant    (grant),
    .ptr_nxt  (rr_ptr_nxt)
  );

  assign req_ready = grant;
  assign issue     = |grant;

  // Encode the one-hot grant and pick the winner's operand slices.
  always_comb begin
    win_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) win_id = IW'(i);
    end
    win_a.sign = req_sign_a[win_id];
    win_a.expo = req_exp_a[win_id*EW +: EW];
    win_a.frac = req_frac_a[win_id*FW +: FW];
    win_b.sign = req_sign_b[win_id];
    win_b.expo = req_exp_b[win_id*EW +: EW];
    win_b.frac = req_frac_b[win_id*FW +: FW];
  end

  // Between issues the adder keeps seeing the last issued operands, so its inputs stay quiet.
  assign add_a = issue ? win_a : hold_a;
  assign add_b = issue ? win_b : hold_b;

  FP21_add u_add (
    .clk      (clk),
    .a_sign   (add_a.sign),
    .a_exp    (add_a.expo),
    .a_frac   (add_a.frac),
    .b_sign   (add_b.sign),
    .b_exp    (add_b.expo),
    .b_frac   (add_b.frac),
    .sum_sign (res_sign),
    .sum_exp  (res_exp),
    .sum_frac (res_frac)
  );

  // Round-robin pointer moves only when something issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rr_ptr <= PTR_RST;
    else if (issue) rr_ptr <= rr_ptr_nxt;
  end

  // Capture the issued operands for the hold path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_a <= '0;
      hold_b <= '0;
    end else if (issue) begin
      hold_a <= win_a;
      hold_b <= win_b;
    end
  end

  // Valid/owner shift register marching in step with the adder pipeline; reset drops
  // everything in flight even though the adder data pipeline keeps stale values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr <= '0;
      for (int s = 0; s < LAT; s++) id_sr[s] <= '0;
    end else begin
      vld_sr   <= {vld_sr[LAT-2:0], issue};
      id_sr[0] <= win_id;
      for (int s = 1; s < LAT; s++) id_sr[s] <= id_sr[s-1];
    end
  end

  // In-flight counters: +1 on issue, -1 on retire, unchanged when both coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) outstanding[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        case ({grant[i], retire[i]})
          2'b10:   outstanding[i] <= outstanding[i] + OW'(1);
          2'b01:   outstanding[i] <= outstanding[i] - OW'(1);
          default: outstanding[i] <= outstanding[i];
        endcase
      end
    end
  end

  assign res_valid = vld_sr[LAT-1];
  assign res_id    = id_sr[LAT-1];
  assign busy      = |vld_sr;

endmodule
